// File: rtl/uart_rx_cmd.sv
// uart_rx_cmd: 8N1 UART receiver with a "$<op><digit>#" command parser.
// The serial line is synchronised and sampled at the middle of each bit.
// Correctly framed bytes are passed to a small parser, which publishes
// accepted opcode/argument pairs.
module uart_rx_cmd #(
   parameter int unsigned CLKS_PER_BIT = 27
) (
   input  logic       clk_3125KHz,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic [7:0] cmd,
   output logic [3:0] arg,
   output logic       cmd_valid
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
   typedef enum logic [1:0] {P_WAIT, P_CMD, P_ARG, P_END} p_state_t;

   // synchroniser and arming
   logic            r_sync1, r_sync2;
   logic [1:0]      r_fill;
   logic            r_armed;
   logic            w_rx;

   // receiver
   rx_state_t       r_state, w_state_nxt;
   logic [CW-1:0]   r_clk_cnt, w_clk_cnt_nxt;
   logic [2:0]      r_bit_idx, w_bit_idx_nxt;
   logic [7:0]      r_shift, w_shift_nxt;
   logic [7:0]      r_rx_data, w_rx_data_nxt;
   logic            r_rx_valid, w_rx_valid_nxt;
   logic            r_frame_err, w_frame_err_nxt;

   // parser
   p_state_t        r_pstate, w_pstate_nxt;
   logic [7:0]      r_pend_cmd, w_pend_cmd_nxt;
   logic [3:0]      r_pend_arg, w_pend_arg_nxt;
   logic [7:0]      r_cmd, w_cmd_nxt;
   logic [3:0]      r_arg, w_arg_nxt;
   logic            r_cmd_valid, w_cmd_valid_nxt;

   logic            w_is_op, w_is_digit;

   assign w_rx = r_sync2;

   // Two-flop synchroniser; r_fill marks when r_sync2 holds a real line
   // sample, and r_armed blocks start detection until the line was seen high.
   always_ff @(posedge clk_3125KHz) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_fill  <= '0;
         r_armed <= 1'b0;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
         r_fill  <= {r_fill[0], 1'b1};
         if (r_fill[1] && w_rx)
            r_armed <= 1'b1;
      end
   end

   // Receive FSM next-state, bit timing, shifting and strobe generation.
   always_comb begin
      w_state_nxt     = r_state;
      w_clk_cnt_nxt   = r_clk_cnt;
      w_bit_idx_nxt   = r_bit_idx;
      w_shift_nxt     = r_shift;
      w_rx_data_nxt   = r_rx_data;
      w_rx_valid_nxt  = 1'b0;
      w_frame_err_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_armed && !w_rx) begin
               w_state_nxt   = START;
               w_clk_cnt_nxt = '0;
               w_bit_idx_nxt = '0;
            end
         end
         START: begin
            if (r_clk_cnt == CNT_HALF) begin
               w_clk_cnt_nxt = '0;
               w_state_nxt   = w_rx ? IDLE : DATA;
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + 1'b1;
            end
         end
         DATA: begin
            if (r_clk_cnt == CNT_FULL) begin
               w_clk_cnt_nxt = '0;
               w_shift_nxt   = {w_rx, r_shift[7:1]};
               w_bit_idx_nxt = r_bit_idx + 3'd1;
               if (r_bit_idx == 3'd7)
                  w_state_nxt = STOP;
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + 1'b1;
            end
         end
         STOP: begin
            if (r_clk_cnt == CNT_FULL) begin
               w_clk_cnt_nxt = '0;
               w_state_nxt   = IDLE;
               if (w_rx) begin
                  w_rx_data_nxt  = r_shift;
                  w_rx_valid_nxt = 1'b1;
               end else begin
                  w_frame_err_nxt = 1'b1;
               end
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Receive FSM state and datapath registers.
   always_ff @(posedge clk_3125KHz) begin
      if (reset) begin
         r_state     <= IDLE;
         r_clk_cnt   <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_clk_cnt   <= w_clk_cnt_nxt;
         r_bit_idx   <= w_bit_idx_nxt;
         r_shift     <= w_shift_nxt;
         r_rx_data   <= w_rx_data_nxt;
         r_rx_valid  <= w_rx_valid_nxt;
         r_frame_err <= w_frame_err_nxt;
      end
   end

   assign w_is_op    = (r_rx_data == 8'h46) || (r_rx_data == 8'h53) ||
                       (r_rx_data == 8'h4C) || (r_rx_data == 8'h52);
   assign w_is_digit = (r_rx_data >= 8'h30) && (r_rx_data <= 8'h39);

   // Parser FSM: advances on each received byte, '$' always restarts a frame.
   always_comb begin
      w_pstate_nxt    = r_pstate;
      w_pend_cmd_nxt  = r_pend_cmd;
      w_pend_arg_nxt  = r_pend_arg;
      w_cmd_nxt       = r_cmd;
      w_arg_nxt       = r_arg;
      w_cmd_valid_nxt = 1'b0;
      if (r_frame_err) begin
         w_pstate_nxt = P_WAIT;
      end else if (r_rx_valid) begin
         if (r_rx_data == 8'h24) begin
            w_pstate_nxt = P_CMD;
         end else begin
            case (r_pstate)
               P_WAIT: w_pstate_nxt = P_WAIT;
               P_CMD: begin
                  if (w_is_op) begin
                     w_pend_cmd_nxt = r_rx_data;
                     w_pstate_nxt   = P_ARG;
                  end else begin
                     w_pstate_nxt = P_WAIT;
                  end
               end
               P_ARG: begin
                  if (w_is_digit) begin
                     // low nibble of an ASCII digit equals its value
                     w_pend_arg_nxt = r_rx_data[3:0];
                     w_pstate_nxt   = P_END;
                  end else begin
                     w_pstate_nxt = P_WAIT;
                  end
               end
               P_END: begin
                  if (r_rx_data == 8'h23) begin
                     w_cmd_nxt       = r_pend_cmd;
                     w_arg_nxt       = r_pend_arg;
                     w_cmd_valid_nxt = 1'b1;
                  end
                  w_pstate_nxt = P_WAIT;
               end
               default: w_pstate_nxt = P_WAIT;
            endcase
         end
      end
   end

   // Parser state and command output registers.
   always_ff @(posedge clk_3125KHz) begin
      if (reset) begin
         r_pstate    <= P_WAIT;
         r_pend_cmd  <= '0;
         r_pend_arg  <= '0;
         r_cmd       <= '0;
         r_arg       <= '0;
         r_cmd_valid <= 1'b0;
      end else begin
         r_pstate    <= w_pstate_nxt;
         r_pend_cmd  <= w_pend_cmd_nxt;
         r_pend_arg  <= w_pend_arg_nxt;
         r_cmd       <= w_cmd_nxt;
         r_arg       <= w_arg_nxt;
         r_cmd_valid <= w_cmd_valid_nxt;
      end
   end

   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign frame_err = r_frame_err;
   assign cmd       = r_cmd;
   assign arg       = r_arg;
   assign cmd_valid = r_cmd_valid;

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Bench for uart_rx_cmd: a directed table of frames, hand sequences for
// glitch/reset corners, and random traffic against a window-based model.
module tb_uart_rx_cmd;

   localparam int unsigned CPB = 27;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic [7:0] cmd;
   logic [3:0] arg;
   logic       cmd_valid;

   uart_rx_cmd #(.CLKS_PER_BIT(CPB)) u_dut (
      .clk_3125KHz (clk),
      .reset       (reset),
      .rx          (rx),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .frame_err   (frame_err),
      .cmd         (cmd),
      .arg         (arg),
      .cmd_valid   (cmd_valid)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // Strobe monitor: cumulative pulse counts and protocol violations
   // (double-length strobes, rx_valid with frame_err, cmd_valid not
   // exactly one cycle after rx_valid).
   int   mon_rxv = 0, mon_fe = 0, mon_cv = 0, mon_proto = 0;
   logic p_rxv = 1'b0, p_fe = 1'b0, p_cv = 1'b0;
   always @(negedge clk) begin
      if (rx_valid)  mon_rxv <= mon_rxv + 1;
      if (frame_err) mon_fe  <= mon_fe + 1;
      if (cmd_valid) mon_cv  <= mon_cv + 1;
      if ((rx_valid && p_rxv) || (frame_err && p_fe) || (cmd_valid && p_cv) ||
          (rx_valid && frame_err) || (cmd_valid && !p_rxv))
         mon_proto <= mon_proto + 1;
      p_rxv <= rx_valid;
      p_fe  <= frame_err;
      p_cv  <= cmd_valid;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b, input int n);
      rx = b;
      tick(n);
   endtask

   // 8N1 frame; a bad stop bit is low for its first 16 clocks then high.
   task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int idle);
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
      if (stop_ok) drive_bit(1'b1, CPB);
      else begin
         drive_bit(1'b0, 16);
         drive_bit(1'b1, CPB - 16);
      end
      if (idle > 0) drive_bit(1'b1, idle);
   endtask

   task automatic frame_check(input string tag, input logic [7:0] d, input bit stop_ok,
                              input int idle, input int e_rxv, input int e_fe, input int e_cv,
                              input logic [7:0] e_rxd, input logic [7:0] e_cmd,
                              input logic [3:0] e_arg);
      int b_rxv, b_fe, b_cv;
      b_rxv = mon_rxv; b_fe = mon_fe; b_cv = mon_cv;
      send_frame(d, stop_ok, idle);
      check({tag, " rx_valid count"},  mon_rxv - b_rxv, e_rxv);
      check({tag, " frame_err count"}, mon_fe - b_fe, e_fe);
      check({tag, " cmd_valid count"}, mon_cv - b_cv, e_cv);
      check({tag, " rx_data"}, rx_data, e_rxd);
      check({tag, " cmd"}, cmd, e_cmd);
      check({tag, " arg"}, arg, e_arg);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, " rx_data"}, rx_data, 8'h00);
      check({tag, " cmd"}, cmd, 8'h00);
      check({tag, " arg"}, arg, 4'h0);
      check({tag, " strobes"}, {rx_valid, frame_err, cmd_valid}, 3'b000);
   endtask

   typedef struct {
      logic [7:0] data;
      bit         stop_ok;
      int         e_rxv;
      int         e_fe;
      int         e_cv;
      logic [7:0] e_rxd;
      logic [7:0] e_cmd;
      logic [3:0] e_arg;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [7:0] d, input bit ok, input int rv, input int fe,
                      input int cv, input logic [7:0] rd, input logic [7:0] c,
                      input logic [3:0] a);
      vec_t v;
      v.data = d; v.stop_ok = ok; v.e_rxv = rv; v.e_fe = fe; v.e_cv = cv;
      v.e_rxd = rd; v.e_cmd = c; v.e_arg = a;
      tbl.push_back(v);
   endtask

   function automatic bit is_op(input logic [7:0] b);
      return (b == 8'h46) || (b == 8'h53) || (b == 8'h4C) || (b == 8'h52);
   endfunction

   function automatic bit is_digit(input logic [7:0] b);
      return (b >= 8'h30) && (b <= 8'h39);
   endfunction

   function automatic logic [7:0] pick_op(input int unsigned i);
      case (i)
         0: return 8'h46;
         1: return 8'h53;
         2: return 8'h4C;
         default: return 8'h52;
      endcase
   endfunction

   // Reference model: a command is accepted when the last four good bytes,
   // uninterrupted by a framing error, read '$', opcode, digit, '#'.
   logic [7:0] win[$];
   logic [7:0] m_rxd, m_cmd;
   logic [3:0] m_arg;
   logic [7:0] gen_d[$];
   bit         gen_ok[$];

   initial begin
      int b_rxv, b_fe, b_cv;
      int cv_exp;

      // reset state
      tick(4);
      check_cleared("reset");
      reset = 1'b0;
      tick(10);
      check_cleared("post-reset idle");

      // directed table
      add(8'hA5,1, 1,0,0, 8'hA5,8'h00,4'd0);
      add(8'h24,1, 1,0,0, 8'h24,8'h00,4'd0);
      add(8'h46,1, 1,0,0, 8'h46,8'h00,4'd0);
      add(8'h35,1, 1,0,0, 8'h35,8'h00,4'd0);
      add(8'h23,1, 1,0,1, 8'h23,8'h46,4'd5);
      add(8'h3C,0, 0,1,0, 8'h23,8'h46,4'd5);
      add(8'h24,1, 1,0,0, 8'h24,8'h46,4'd5);
      add(8'h53,1, 1,0,0, 8'h53,8'h46,4'd5);
      add(8'h30,1, 1,0,0, 8'h30,8'h46,4'd5);
      add(8'h23,1, 1,0,1, 8'h23,8'h53,4'd0);
      add(8'h24,1, 1,0,0, 8'h24,8'h53,4'd0);
      add(8'h4C,1, 1,0,0, 8'h4C,8'h53,4'd0);
      add(8'h24,1, 1,0,0, 8'h24,8'h53,4'd0);
      add(8'h52,1, 1,0,0, 8'h52,8'h53,4'd0);
      add(8'h39,1, 1,0,0, 8'h39,8'h53,4'd0);
      add(8'h23,1, 1,0,1, 8'h23,8'h52,4'd9);
      add(8'h24,1, 1,0,0, 8'h24,8'h52,4'd9);
      add(8'h4C,1, 1,0,0, 8'h4C,8'h52,4'd9);
      add(8'h58,1, 1,0,0, 8'h58,8'h52,4'd9);
      add(8'h23,1, 1,0,0, 8'h23,8'h52,4'd9);
      add(8'h24,1, 1,0,0, 8'h24,8'h52,4'd9);
      add(8'h46,1, 1,0,0, 8'h46,8'h52,4'd9);
      add(8'h35,0, 0,1,0, 8'h46,8'h52,4'd9);
      add(8'h23,1, 1,0,0, 8'h23,8'h52,4'd9);
      add(8'h24,1, 1,0,0, 8'h24,8'h52,4'd9);
      add(8'h52,1, 1,0,0, 8'h52,8'h52,4'd9);
      add(8'h3A,1, 1,0,0, 8'h3A,8'h52,4'd9);
      add(8'h23,1, 1,0,0, 8'h23,8'h52,4'd9);
      add(8'h24,1, 1,0,0, 8'h24,8'h52,4'd9);
      add(8'h53,1, 1,0,0, 8'h53,8'h52,4'd9);
      add(8'h2F,1, 1,0,0, 8'h2F,8'h52,4'd9);
      add(8'h23,1, 1,0,0, 8'h23,8'h52,4'd9);
      add(8'h24,1, 1,0,0, 8'h24,8'h52,4'd9);
      add(8'h53,1, 1,0,0, 8'h53,8'h52,4'd9);
      add(8'h39,1, 1,0,0, 8'h39,8'h52,4'd9);
      add(8'h24,1, 1,0,0, 8'h24,8'h52,4'd9);
      add(8'h46,1, 1,0,0, 8'h46,8'h52,4'd9);
      add(8'h30,1, 1,0,0, 8'h30,8'h52,4'd9);
      add(8'h23,1, 1,0,1, 8'h23,8'h46,4'd0);
      for (int i = 0; i < tbl.size(); i++)
         frame_check($sformatf("tbl[%0d]", i), tbl[i].data, tbl[i].stop_ok,
                     tbl[i].stop_ok ? 0 : 40, tbl[i].e_rxv, tbl[i].e_fe, tbl[i].e_cv,
                     tbl[i].e_rxd, tbl[i].e_cmd, tbl[i].e_arg);

      // reset during bit 4 of 0xC3, then a clean 0x5A
      b_rxv = mon_rxv; b_fe = mon_fe; b_cv = mon_cv;
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 4; i++) drive_bit(((8'hC3 >> i) & 8'h01) != 0, CPB);
      drive_bit(1'b0, 13);
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      drive_bit(1'b1, 40);
      check("midbyte reset strobes", (mon_rxv - b_rxv) + (mon_fe - b_fe) + (mon_cv - b_cv), 0);
      check_cleared("midbyte reset");
      frame_check("after midbyte reset", 8'h5A, 1, 5, 1, 0, 0, 8'h5A, 8'h00, 4'd0);

      // 5-cycle low glitch on idle line
      b_rxv = mon_rxv; b_fe = mon_fe;
      drive_bit(1'b0, 5);
      drive_bit(1'b1, 60);
      check("glitch rx_valid", mon_rxv - b_rxv, 0);
      check("glitch frame_err", mon_fe - b_fe, 0);
      frame_check("after glitch", 8'h96, 1, 5, 1, 0, 0, 8'h96, 8'h00, 4'd0);

      // line held low across reset release: no start until seen high
      rx = 1'b0;
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      b_rxv = mon_rxv; b_fe = mon_fe;
      drive_bit(1'b0, 300);
      check("low-after-reset rx_valid", mon_rxv - b_rxv, 0);
      check("low-after-reset frame_err", mon_fe - b_fe, 0);
      drive_bit(1'b1, 20);
      frame_check("after line rises", 8'h81, 1, 5, 1, 0, 0, 8'h81, 8'h00, 4'd0);

      // random traffic from a clean reset
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      drive_bit(1'b1, 10);
      check_cleared("pre-random reset");
      m_rxd = 8'h00; m_cmd = 8'h00; m_arg = 4'd0;
      win.delete();
      for (int it = 0; it < 18; it++) begin
         if ($urandom_range(0, 2) != 0) begin
            gen_d.push_back(8'h24);
            gen_d.push_back(pick_op($urandom_range(0, 3)));
            gen_d.push_back(8'h30 + 8'($urandom_range(0, 9)));
            gen_d.push_back(8'h23);
            for (int j = 1; j <= 4; j++)
               if ($urandom_range(0, 7) == 0) gen_d[gen_d.size() - j] = 8'($urandom_range(0, 255));
         end else begin
            gen_d.push_back(8'($urandom_range(0, 255)));
         end
      end
      for (int i = 0; i < gen_d.size(); i++) gen_ok.push_back($urandom_range(0, 11) != 0);
      for (int i = 0; i < gen_d.size(); i++) begin
         cv_exp = 0;
         if (gen_ok[i]) begin
            m_rxd = gen_d[i];
            win.push_back(gen_d[i]);
            if (win.size() > 4) void'(win.pop_front());
            if (win.size() == 4 && win[0] == 8'h24 && is_op(win[1]) &&
                is_digit(win[2]) && win[3] == 8'h23) begin
               cv_exp = 1;
               m_cmd  = win[1];
               m_arg  = 4'(win[2] - 8'h30);
            end
         end else begin
            win.delete();
         end
         frame_check($sformatf("rnd[%0d]", i), gen_d[i], gen_ok[i],
                     gen_ok[i] ? int'($urandom_range(0, 20)) : 40,
                     gen_ok[i] ? 1 : 0, gen_ok[i] ? 0 : 1, cv_exp, m_rxd, m_cmd, m_arg);
      end

      tick(2);
      check("strobe protocol violations", mon_proto, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
